// File: rtl/nonce_scanner.sv
// nonce_scanner: feeds one nonce at a time to sha256 and reports hashes <= target (NONCE_SCANNER_STATS_EN adds hashes_done).
// Latency: accept -> sha_start next cycle; 3 + L cycles per nonce; CHECK -> found_valid next cycle.
// Backpressure: job_ready only in IDLE; a hit is held in FOUND until found_ack.
module nonce_scanner #(
  parameter int MAX_LAT = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         job_valid,
  output logic         job_ready,
  input  logic [607:0] job_header,
  input  logic [255:0] job_target,
  input  logic [31:0]  job_nonce_start,
  input  logic [31:0]  job_nonce_end,
  input  logic         abort,
  output logic         sha_start,
  output logic [639:0] sha_data,
  input  logic         sha_ready,
  input  logic [255:0] sha_hash,
  output logic         found_valid,
  output logic [31:0]  found_nonce,
  output logic [255:0] found_hash,
  input  logic         found_ack,
  output logic         busy,
  output logic         exhausted,
  output logic         sha_timeout,
  output logic [31:0]  hashes_done
);

  localparam int WDW = $clog2(MAX_LAT + 1);

  typedef enum logic [2:0] {IDLE, ISSUE, SETTLE, WAIT, CHECK, FOUND, DRAIN} state_t;

  state_t         state, state_nxt;
  logic [607:0]   header_reg;
  logic [255:0]   target_reg;
  logic [31:0]    nonce, nonce_end;
  logic [WDW-1:0] wd;
  logic           accept, hit, last, wd_expired, exhaust_nxt, timeout_nxt;

  assign accept     = (state == IDLE) && job_valid;
  assign hit        = (sha_hash <= target_reg);
  assign last       = (nonce == nonce_end);
  // wd counts cycles since SETTLE, so the wait gives up after MAX_LAT cycles
  assign wd_expired = (wd == WDW'(MAX_LAT - 1));
  assign sha_data   = {header_reg, nonce};

  always_comb begin
    state_nxt   = state;
    exhaust_nxt = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      IDLE:   if (job_valid) state_nxt = ISSUE;
      ISSUE:  state_nxt = abort ? DRAIN : SETTLE;
      SETTLE: state_nxt = abort ? DRAIN : WAIT;
      WAIT: begin
        if (abort) state_nxt = DRAIN;
        else if (sha_ready) state_nxt = CHECK;
        else if (wd_expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      CHECK: begin
        if (abort) state_nxt = IDLE;
        else if (hit) state_nxt = FOUND;
        else if (last) begin
          exhaust_nxt = 1'b1;
          state_nxt   = IDLE;
        end else state_nxt = ISSUE;
      end
      FOUND: begin
        if (abort) state_nxt = IDLE;
        else if (found_ack) begin
          exhaust_nxt = last;
          state_nxt   = last ? IDLE : ISSUE;
        end
      end
      DRAIN: begin
        if (sha_ready) state_nxt = IDLE;
        else if (wd_expired) begin
          timeout_nxt = 1'b1;
          state_nxt   = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      job_ready   <= 1'b1;
      busy        <= 1'b0;
      sha_start   <= 1'b0;
      found_valid <= 1'b0;
      exhausted   <= 1'b0;
      sha_timeout <= 1'b0;
      header_reg  <= '0;
      target_reg  <= '0;
      nonce       <= '0;
      nonce_end   <= '0;
      found_nonce <= '0;
      found_hash  <= '0;
      wd          <= '0;
    end else begin
      state       <= state_nxt;
      job_ready   <= (state_nxt == IDLE);
      busy        <= (state_nxt != IDLE);
      sha_start   <= (state_nxt == ISSUE);
      found_valid <= (state_nxt == FOUND);
      exhausted   <= exhaust_nxt;
      if (accept) begin
        header_reg  <= job_header;
        target_reg  <= job_target;
        nonce       <= job_nonce_start;
        nonce_end   <= job_nonce_end;
        sha_timeout <= 1'b0;
      end else begin
        if (timeout_nxt) sha_timeout <= 1'b1;
        if (state_nxt == ISSUE) nonce <= nonce + 32'd1;
      end
      if (state == ISSUE) wd <= '0;
      else if (state inside {SETTLE, WAIT, DRAIN}) wd <= wd + WDW'(1);
      if (state == CHECK && !abort && hit) begin
        found_nonce <= nonce;
        found_hash  <= sha_hash;
      end
    end
  end

`ifdef NONCE_SCANNER_STATS_EN
  logic [31:0] hcnt;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hcnt <= '0;
    else if (accept) hcnt <= '0;
    else if (state == CHECK && !abort && hcnt != 32'hFFFF_FFFF) hcnt <= hcnt + 32'd1;
  end
  assign hashes_done = hcnt;
`else
  assign hashes_done = '0;
`endif

endmodule
